// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the 32-word data memory: latches one command,
// strobes the memory for a single ACCESS cycle, then pulses done to the winner.
module dmem_arbiter #(
    parameter int unsigned AW         = 32'd5,
    parameter int unsigned DW         = 32'd32,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [31:0]   r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_done,
    output logic          r0_err,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [31:0]   r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_done,
    output logic          r1_err,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_we,
    output logic          mem_re,
    output logic [31:0]   mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e          state_q;
    logic            last_gnt_q;
    logic            cmd_port_q;
    logic            cmd_we_q;
    logic            cmd_err_q;
    logic [31:0]     mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic            mem_we_q;
    logic            mem_re_q;
    logic            gnt0_q;
    logic            gnt1_q;
    logic            done0_q;
    logic            done1_q;
    logic            err0_q;
    logic            err1_q;
    logic [DW-1:0]   rdata0_q;
    logic [DW-1:0]   rdata1_q;

    logic            arb_valid_s;
    logic            arb_port_s;
    logic            sel_we_s;
    logic [31:0]     sel_addr_s;
    logic [DW-1:0]   sel_wdata_s;
    logic            sel_oor_s;

    // Any address bit above the decoded range marks the access as out of range.
    function automatic logic addr_oor(input logic [31:0] a);
        return (a >> AW) != 32'd0;
    endfunction

    // Pick the winner among active requesters and mux its command fields.
    always_comb begin
        arb_valid_s = r0_req | r1_req;
        if (r0_req && r1_req) begin
            if (FIXED_PRIO) begin
                arb_port_s = 1'b0;
            end else begin
                arb_port_s = ~last_gnt_q;
            end
        end else if (r1_req) begin
            arb_port_s = 1'b1;
        end else begin
            arb_port_s = 1'b0;
        end

        if (arb_port_s) begin
            sel_we_s    = r1_we;
            sel_addr_s  = r1_addr;
            sel_wdata_s = r1_wdata;
        end else begin
            sel_we_s    = r0_we;
            sel_addr_s  = r0_addr;
            sel_wdata_s = r0_wdata;
        end
        sel_oor_s = addr_oor(sel_addr_s);
    end

    // Transaction FSM; every output is a register set up one state ahead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_gnt_q  <= 1'b1;
            cmd_port_q  <= 1'b0;
            cmd_we_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            err0_q      <= 1'b0;
            err1_q      <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_valid_s) begin
                        state_q     <= ST_ACCESS;
                        last_gnt_q  <= arb_port_s;
                        cmd_port_q  <= arb_port_s;
                        cmd_we_q    <= sel_we_s;
                        cmd_err_q   <= sel_oor_s;
                        mem_addr_q  <= sel_addr_s;
                        mem_wdata_q <= sel_wdata_s;
                        mem_we_q    <= sel_we_s & ~sel_oor_s;
                        mem_re_q    <= ~sel_we_s & ~sel_oor_s;
                        gnt0_q      <= ~arb_port_s;
                        gnt1_q      <= arb_port_s;
                    end
                end
                ST_ACCESS: begin
                    state_q  <= ST_DONE;
                    mem_we_q <= 1'b0;
                    mem_re_q <= 1'b0;
                    gnt0_q   <= 1'b0;
                    gnt1_q   <= 1'b0;
                    done0_q  <= ~cmd_port_q;
                    done1_q  <= cmd_port_q;
                    err0_q   <= ~cmd_port_q & cmd_err_q;
                    err1_q   <= cmd_port_q & cmd_err_q;
                    // Only successful reads update the requester's data register.
                    if (!cmd_we_q && !cmd_err_q) begin
                        if (cmd_port_q) begin
                            rdata1_q <= mem_rdata;
                        end else begin
                            rdata0_q <= mem_rdata;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    err0_q  <= 1'b0;
                    err1_q  <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    mem_we_q <= 1'b0;
                    mem_re_q <= 1'b0;
                    gnt0_q   <= 1'b0;
                    gnt1_q   <= 1'b0;
                    done0_q  <= 1'b0;
                    done1_q  <= 1'b0;
                    err0_q   <= 1'b0;
                    err1_q   <= 1'b0;
                end
            endcase
        end
    end

    assign r0_gnt    = gnt0_q;
    assign r0_done   = done0_q;
    assign r0_err    = err0_q;
    assign r0_rdata  = rdata0_q;
    assign r1_gnt    = gnt1_q;
    assign r1_done   = done1_q;
    assign r1_err    = err1_q;
    assign r1_rdata  = rdata1_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
